// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage load/store initiator driving a doubleword RAM port.
// Splits boundary-crossing accesses, turns partial stores into read-modify-write.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid_i / req_ready_o  request handshake (accept on valid & ready)
//   req_we_i, req_addr_i       store flag, byte address
//   req_size_i                 0=byte 1=half 2=word 3=dword
//   req_unsigned_i             zero-extend loads when set
//   req_wdata_i                right-justified store data
//   resp_valid_o, resp_rdata_o one-cycle completion pulse, extended load data
//   mem_idx_o                  RAM doubleword index
//   mem_ren_o, mem_wen_o       RAM read / write enables
//   mem_read_type_o            constant raw 64-bit read type
//   mem_write_type_o           constant full-doubleword write type
//   mem_w_data_o, mem_r_data_i RAM write data / combinational read data
module lsu_mem_ctrl #(
    parameter int ADDR_LEN = 64,
    parameter int IDX_LEN  = 61,
    parameter int DATA_LEN = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [ADDR_LEN-1:0] req_addr_i,
    input  logic [1:0]          req_size_i,
    input  logic                req_unsigned_i,
    input  logic [DATA_LEN-1:0] req_wdata_i,
    output logic                resp_valid_o,
    output logic [DATA_LEN-1:0] resp_rdata_o,
    output logic [IDX_LEN-1:0]  mem_idx_o,
    output logic                mem_ren_o,
    output logic                mem_wen_o,
    output logic [2:0]          mem_read_type_o,
    output logic [1:0]          mem_write_type_o,
    output logic [DATA_LEN-1:0] mem_w_data_o,
    input  logic [DATA_LEN-1:0] mem_r_data_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_WR0,
        S_WR1,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                r_we;
    logic                r_uns;
    logic [1:0]          r_size;
    logic [2:0]          r_off;
    logic [IDX_LEN-1:0]  r_idx0;
    logic [DATA_LEN-1:0] r_wdata;
    logic [DATA_LEN-1:0] r_buf0;
    logic [DATA_LEN-1:0] r_buf1;

    logic                  w_accept;
    logic                  w_full_st;
    logic [3:0]            w_n;
    logic                  w_cross;
    logic [IDX_LEN-1:0]    w_idx1;
    logic [15:0]           w_bmask;
    logic [2*DATA_LEN-1:0] w_mask;
    logic [2*DATA_LEN-1:0] w_cat;
    logic [2*DATA_LEN-1:0] w_wsh;
    logic [2*DATA_LEN-1:0] w_merged;
    logic [DATA_LEN-1:0]   w_raw;
    logic [DATA_LEN-1:0]   w_ext;

    assign mem_read_type_o  = 3'd3;
    assign mem_write_type_o = 2'd3;

    assign w_accept  = req_valid_i && (r_state == S_IDLE);
    // Aligned dword stores overwrite the whole doubleword, so no read is needed.
    assign w_full_st = req_we_i && (req_size_i == 2'd3)
                     && (req_addr_i[2:0] == 3'd0);

    assign w_n     = 4'd1 << r_size;
    assign w_cross = ({1'b0, r_off} + w_n) > 4'd8;
    // Index wrap-around past the top of RAM is intentional.
    assign w_idx1  = r_idx0 + {{(IDX_LEN-1){1'b0}}, 1'b1};

    assign w_bmask = ((16'd1 << w_n) - 16'd1) << r_off;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < 16; i++) begin
            w_mask[8*i +: 8] = {8{w_bmask[i]}};
        end
    end

    assign w_cat    = {r_buf1, r_buf0};
    assign w_wsh    = {{DATA_LEN{1'b0}}, r_wdata} << {r_off, 3'b000};
    assign w_merged = (w_cat & ~w_mask) | (w_wsh & w_mask);
    assign w_raw    = DATA_LEN'(w_cat >> {r_off, 3'b000});

    always_comb begin
        w_ext = w_raw;
        unique case (r_size)
            2'd0: w_ext = r_uns ? {{(DATA_LEN-8){1'b0}}, w_raw[7:0]}
                                : {{(DATA_LEN-8){w_raw[7]}}, w_raw[7:0]};
            2'd1: w_ext = r_uns ? {{(DATA_LEN-16){1'b0}}, w_raw[15:0]}
                                : {{(DATA_LEN-16){w_raw[15]}}, w_raw[15:0]};
            2'd2: w_ext = r_uns ? {{(DATA_LEN-32){1'b0}}, w_raw[31:0]}
                                : {{(DATA_LEN-32){w_raw[31]}}, w_raw[31:0]};
            default: w_ext = w_raw;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= 2'd0;
            r_off   <= 3'd0;
            r_idx0  <= '0;
            r_wdata <= '0;
            r_buf0  <= '0;
            r_buf1  <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we_i;
                r_uns   <= req_unsigned_i;
                r_size  <= req_size_i;
                r_off   <= req_addr_i[2:0];
                r_idx0  <= req_addr_i[IDX_LEN+2:3];
                r_wdata <= req_wdata_i;
            end
            if (r_state == S_RD0) begin
                r_buf0 <= mem_r_data_i;
            end
            if (r_state == S_RD1) begin
                r_buf1 <= mem_r_data_i;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        req_ready_o  = 1'b0;
        mem_ren_o    = 1'b0;
        mem_wen_o    = 1'b0;
        mem_idx_o    = '0;
        mem_w_data_o = '0;
        resp_valid_o = 1'b0;
        resp_rdata_o = '0;
        unique case (r_state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    w_next = w_full_st ? S_WR0 : S_RD0;
                end
            end
            S_RD0: begin
                mem_ren_o = 1'b1;
                mem_idx_o = r_idx0;
                if (w_cross) begin
                    w_next = S_RD1;
                end else if (r_we) begin
                    w_next = S_WR0;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_RD1: begin
                mem_ren_o = 1'b1;
                mem_idx_o = w_idx1;
                w_next    = r_we ? S_WR0 : S_DONE;
            end
            S_WR0: begin
                mem_wen_o    = 1'b1;
                mem_idx_o    = r_idx0;
                mem_w_data_o = w_merged[DATA_LEN-1:0];
                w_next       = w_cross ? S_WR1 : S_DONE;
            end
            S_WR1: begin
                mem_wen_o    = 1'b1;
                mem_idx_o    = w_idx1;
                mem_w_data_o = w_merged[2*DATA_LEN-1:DATA_LEN];
                w_next       = S_DONE;
            end
            S_DONE: begin
                resp_valid_o = 1'b1;
                resp_rdata_o = r_we ? '0 : w_ext;
                w_next       = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed self-checking bench for lsu_mem_ctrl.
// Small RAM model covers indices 0..7 and the top index.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [63:0] req_addr_i = '0;
    logic [1:0]  req_size_i = '0;
    logic        req_unsigned_i = 1'b0;
    logic [63:0] req_wdata_i = '0;
    logic        resp_valid_o;
    logic [63:0] resp_rdata_o;
    logic [60:0] mem_idx_o;
    logic        mem_ren_o;
    logic        mem_wen_o;
    logic [2:0]  mem_read_type_o;
    logic [1:0]  mem_write_type_o;
    logic [63:0] mem_w_data_o;
    logic [63:0] mem_r_data_i = '0;

    int checks = 0;
    int errors = 0;

    logic [60:0] IDX_MAX = '1;
    logic [63:0] ram [0:7];
    logic [63:0] ram_max;
    logic        pl_we = 1'b0;
    logic [60:0] pl_idx = '0;
    logic [63:0] pl_data = '0;

    int          lat;
    logic [63:0] rdat;
    int          ntr;
    logic [7:0]  tr_ren;
    logic [7:0]  tr_wen;
    logic [60:0] tr_idx [0:7];

    lsu_mem_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_we_i         (req_we_i),
        .req_addr_i       (req_addr_i),
        .req_size_i       (req_size_i),
        .req_unsigned_i   (req_unsigned_i),
        .req_wdata_i      (req_wdata_i),
        .resp_valid_o     (resp_valid_o),
        .resp_rdata_o     (resp_rdata_o),
        .mem_idx_o        (mem_idx_o),
        .mem_ren_o        (mem_ren_o),
        .mem_wen_o        (mem_wen_o),
        .mem_read_type_o  (mem_read_type_o),
        .mem_write_type_o (mem_write_type_o),
        .mem_w_data_o     (mem_w_data_o),
        .mem_r_data_i     (mem_r_data_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_we) begin
            if (pl_idx == IDX_MAX) ram_max <= pl_data;
            else if (pl_idx < 61'd8) ram[pl_idx[2:0]] <= pl_data;
        end else if (mem_wen_o) begin
            if (mem_idx_o == IDX_MAX) ram_max <= mem_w_data_o;
            else if (mem_idx_o < 61'd8) ram[mem_idx_o[2:0]] <= mem_w_data_o;
        end
    end

    always @(negedge clk) begin
        if (mem_idx_o == IDX_MAX) mem_r_data_i <= ram_max;
        else if (mem_idx_o < 61'd8) mem_r_data_i <= ram[mem_idx_o[2:0]];
        else mem_r_data_i <= '0;
    end

    task automatic preload(input logic [60:0] idx, input logic [63:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_idx = idx; pl_data = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [63:0] addr,
                         input logic [1:0] size, input logic uns,
                         input logic [63:0] wd);
        bit got;
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr;
        req_size_i = size; req_unsigned_i = uns; req_wdata_i = wd;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        got = 1'b0; ntr = 0; lat = 0; rdat = '0;
        tr_ren = '0; tr_wen = '0;
        for (int c = 1; c <= 12 && !got; c++) begin
            @(negedge clk);
            if (resp_valid_o) begin
                got = 1'b1; lat = c; rdat = resp_rdata_o;
            end else if (ntr < 8) begin
                tr_ren[ntr] = mem_ren_o; tr_wen[ntr] = mem_wen_o;
                tr_idx[ntr] = mem_idx_o; ntr++;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL timeout: no resp_valid_o within 12 cycles");
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({req_ready_o, mem_ren_o, mem_wen_o, resp_valid_o} !== 4'b1000) begin
            errors++;
            $display("FAIL rst_ctrl: got %b want 1000",
                     {req_ready_o, mem_ren_o, mem_wen_o, resp_valid_o});
        end
        checks++;
        if ({resp_rdata_o, mem_w_data_o, mem_idx_o} !== '0) begin
            errors++;
            $display("FAIL rst_data: rdata %h wdata %h idx %h want 0",
                     resp_rdata_o, mem_w_data_o, mem_idx_o);
        end
        checks++;
        if ({mem_read_type_o, mem_write_type_o} !== 5'b011_11) begin
            errors++;
            $display("FAIL types: got %b want 01111",
                     {mem_read_type_o, mem_write_type_o});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) preload(61'(i), 64'd0);
        preload(IDX_MAX, 64'd0);
        @(negedge clk);
        checks++;
        if ({req_ready_o, mem_ren_o, mem_wen_o, resp_valid_o} !== 4'b1000) begin
            errors++;
            $display("FAIL post_rst: got %b want 1000",
                     {req_ready_o, mem_ren_o, mem_wen_o, resp_valid_o});
        end
    endtask

    task automatic test_dword();
        issue(1'b1, 64'h10, 2'd3, 1'b0, 64'h1122334455667788);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL st64_lat: got %0d want 2", lat); end
        checks++;
        if ({ntr[3:0], tr_ren[0], tr_wen[0], tr_idx[0]} !== {4'd1, 1'b0, 1'b1, 61'd2}) begin
            errors++;
            $display("FAIL st64_seq: ntr %0d ren %b wen %b idx %0h want 1 0 1 2",
                     ntr, tr_ren[0], tr_wen[0], tr_idx[0]);
        end
        checks++;
        if (ram[2] !== 64'h1122334455667788) begin
            errors++; $display("FAIL st64_ram: got %h want 1122334455667788", ram[2]);
        end
        issue(1'b0, 64'h10, 2'd3, 1'b0, 64'd0);
        checks++;
        if (lat !== 2 || rdat !== 64'h1122334455667788) begin
            errors++;
            $display("FAIL ld64: lat %0d data %h want 2 1122334455667788", lat, rdat);
        end
    endtask

    task automatic test_byte();
        issue(1'b1, 64'h13, 2'd0, 1'b0, 64'hAB);
        checks++;
        if (lat !== 3 || tr_ren[1:0] !== 2'b01 || tr_wen[1:0] !== 2'b10
            || tr_idx[0] !== 61'd2 || tr_idx[1] !== 61'd2) begin
            errors++;
            $display("FAIL sb_seq: lat %0d ren %b wen %b want 3 01 10", lat,
                     tr_ren[1:0], tr_wen[1:0]);
        end
        checks++;
        if (ram[2] !== 64'h11223344AB667788) begin
            errors++; $display("FAIL sb_ram: got %h want 11223344ab667788", ram[2]);
        end
        issue(1'b0, 64'h13, 2'd0, 1'b0, 64'd0);
        checks++;
        if (lat !== 2 || rdat !== 64'hFFFFFFFFFFFFFFAB) begin
            errors++; $display("FAIL lb: lat %0d data %h want 2 ffffffffffffffab", lat, rdat);
        end
        issue(1'b0, 64'h13, 2'd0, 1'b1, 64'd0);
        checks++;
        if (rdat !== 64'hAB) begin
            errors++; $display("FAIL lbu: got %h want ab", rdat);
        end
    endtask

    task automatic test_cross();
        preload(61'd3, 64'h0102030405060708);
        preload(61'd4, 64'h1112131415161718);
        issue(1'b1, 64'h1E, 2'd2, 1'b0, 64'hDEADBEEF);
        checks++;
        if (lat !== 5 || tr_ren[3:0] !== 4'b0011 || tr_wen[3:0] !== 4'b1100) begin
            errors++;
            $display("FAIL sw_x_seq: lat %0d ren %b wen %b want 5 0011 1100",
                     lat, tr_ren[3:0], tr_wen[3:0]);
        end
        checks++;
        if (tr_idx[0] !== 61'd3 || tr_idx[1] !== 61'd4
            || tr_idx[2] !== 61'd3 || tr_idx[3] !== 61'd4) begin
            errors++;
            $display("FAIL sw_x_idx: got %0h %0h %0h %0h want 3 4 3 4",
                     tr_idx[0], tr_idx[1], tr_idx[2], tr_idx[3]);
        end
        checks++;
        if (ram[3] !== 64'hBEEF030405060708 || ram[4] !== 64'h111213141516DEAD) begin
            errors++;
            $display("FAIL sw_x_ram: got %h %h want beef030405060708 111213141516dead",
                     ram[3], ram[4]);
        end
        issue(1'b0, 64'h1E, 2'd2, 1'b0, 64'd0);
        checks++;
        if (lat !== 3 || rdat !== 64'hFFFFFFFFDEADBEEF) begin
            errors++;
            $display("FAIL lw_x: lat %0d data %h want 3 ffffffffdeadbeef", lat, rdat);
        end
        issue(1'b0, 64'h1E, 2'd2, 1'b1, 64'd0);
        checks++;
        if (rdat !== 64'h00000000DEADBEEF) begin
            errors++; $display("FAIL lwu_x: got %h want deadbeef", rdat);
        end
    endtask

    task automatic test_wrap();
        preload(IDX_MAX, 64'hAA00000000000000);
        preload(61'd0, 64'h0000000000000081);
        issue(1'b0, 64'hFFFFFFFFFFFFFFFF, 2'd1, 1'b0, 64'd0);
        checks++;
        if (lat !== 3 || tr_idx[0] !== IDX_MAX || tr_idx[1] !== 61'd0) begin
            errors++;
            $display("FAIL wrap_idx: lat %0d idx %h %h want 3 max 0",
                     lat, tr_idx[0], tr_idx[1]);
        end
        checks++;
        if (rdat !== 64'hFFFFFFFFFFFF81AA) begin
            errors++; $display("FAIL wrap_data: got %h want ffffffffffff81aa", rdat);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp [0:3];
        int k, nresp, nready;
        bit acc;
        exp[0] = 64'hA0A1A2A3A4A5A6A7;
        exp[1] = 64'hB0B1B2B3B4B5B6B7;
        exp[2] = 64'hC0C1C2C3C4C5C6C7;
        exp[3] = 64'hD0D1D2D3D4D5D6D7;
        for (int i = 0; i < 4; i++) preload(61'(i + 4), exp[i]);
        @(negedge clk);
        k = 0; nresp = 0; nready = 0;
        req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd3;
        req_unsigned_i = 1'b0; req_addr_i = 64'h20;
        for (int c = 0; c < 60 && nresp < 4; c++) begin
            if (c != 0) @(negedge clk);
            checks++;
            if (req_ready_o && (mem_ren_o || mem_wen_o || resp_valid_o)) begin
                errors++;
                $display("FAIL b2b_ready: ready high while busy (cycle %0d)", c);
            end
            if (req_ready_o) nready++;
            if (resp_valid_o) begin
                checks++;
                if (resp_rdata_o !== exp[nresp]) begin
                    errors++;
                    $display("FAIL b2b_data%0d: got %h want %h", nresp,
                             resp_rdata_o, exp[nresp]);
                end
                nresp++;
            end
            acc = req_ready_o && req_valid_i;
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k == 4) req_valid_i = 1'b0;
                else req_addr_i = 64'h20 + 64'(8 * k);
            end
        end
        req_valid_i = 1'b0;
        checks++;
        if (nresp !== 4 || nready !== 4) begin
            errors++;
            $display("FAIL b2b_count: resp %0d ready %0d want 4 4", nresp, nready);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        preload(61'd5, 64'h5555555555555555);
        preload(61'd6, 64'h6666666666666666);
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 64'h2C;
        req_size_i = 2'd3; req_wdata_i = 64'hCAFEF00DCAFEF00D;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            @(negedge clk);
            if (mem_wen_o) found = 1'b1;
        end
        checks++;
        if (!found || mem_idx_o !== 61'd5) begin
            errors++; $display("FAIL mid_wr0: found %0d idx %h want 1 5", found, mem_idx_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready_o, mem_ren_o, mem_wen_o, resp_valid_o} !== 4'b1000
            || mem_idx_o !== '0 || mem_w_data_o !== '0) begin
            errors++;
            $display("FAIL mid_rst: ctl %b idx %h wd %h want 1000 0 0",
                     {req_ready_o, mem_ren_o, mem_wen_o, resp_valid_o},
                     mem_idx_o, mem_w_data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (ram[5] !== 64'h5555555555555555 || ram[6] !== 64'h6666666666666666) begin
            errors++;
            $display("FAIL mid_ram: got %h %h want 5555.. 6666..", ram[5], ram[6]);
        end
        issue(1'b0, 64'h30, 2'd3, 1'b0, 64'd0);
        checks++;
        if (lat !== 2 || rdat !== 64'h6666666666666666) begin
            errors++;
            $display("FAIL mid_next: lat %0d data %h want 2 6666666666666666", lat, rdat);
        end
    endtask

    initial begin
        test_reset();
        test_dword();
        test_byte();
        test_cross();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
